dcdc_quiet_ctrl: RTL and testbench

Sequencer that sits directly upstream of `dcdc_sync` and drives its `en` and `state_out` inputs. On an acquisition request it parks the DC-DC switching clock at a static level without a runt pulse, waits a guard interval, then opens a quiet acquisition window for the ADC capture logic. After the window it re-enables synchronous switching. Consumer contract: `dcdc_sync` outputs its divided clock when `en=1`; when `en=0` it drives `dcdc_clk = state_out`.

---
 rtl/dcdc_pkg.sv | 19 +
 rtl/dcdc_down_counter.sv | 30 +++
 rtl/dcdc_quiet_ctrl.sv | 140 ++++++++++++++
 tb/tb_dcdc_quiet_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/dcdc_pkg.sv
// Shared definitions for the DC-DC quiet-window sequencer: FSM states,
// default sizing and the dcdc_sync consumer contract.
package dcdc_pkg;

   localparam int DEF_CNT_WIDTH     = 16;
   localparam int DEF_ALIGN_TIMEOUT = 64;

   typedef logic [1:0] state_t;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ALIGN = 2'd1;
   localparam logic [1:0] ST_GUARD = 2'd2;
   localparam logic [1:0] ST_ACQ   = 2'd3;

   // dcdc_sync drives its divided clock when en is high, otherwise dcdc_clk = state_out
   localparam logic DCDC_EN_SWITCH = 1'b1;
   localparam logic DCDC_EN_PARK   = 1'b0;

endpackage

// File: rtl/dcdc_down_counter.sv
// Loadable down-counter with zero flag; shared by the guard and window phases.
module dcdc_down_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = load_val;
      else if (dec && (cnt_q != '0))
         cnt_d = cnt_q - W'(1);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/dcdc_quiet_ctrl.sv
// Parks the DC-DC switching clock without a runt pulse, waits a guard
// interval, then opens a quiet acquisition window before resuming switching.
module dcdc_quiet_ctrl
   import dcdc_pkg::*;
#(
   parameter int CNT_WIDTH     = DEF_CNT_WIDTH,
   parameter int ALIGN_TIMEOUT = DEF_ALIGN_TIMEOUT
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 sync_enable,
   input  logic                 park_level,
   input  logic                 acq_start,
   input  logic [CNT_WIDTH-1:0] pre_guard,
   input  logic [CNT_WIDTH-1:0] acq_len,
   input  logic                 dcdc_clk_fb,
   input  logic                 flags_clr,
   output logic                 en,
   output logic                 state_out,
   output logic                 acq_window,
   output logic                 busy,
   output logic                 overrun,
   output logic                 align_err
);

   localparam int              AW         = $clog2(ALIGN_TIMEOUT) + 1;
   localparam logic [AW-1:0]   ALIGN_LAST = AW'(ALIGN_TIMEOUT - 1);

   logic [1:0]           state_q, state_d;
   logic                 en_q, en_d;
   logic                 state_out_q, state_out_d;
   logic                 acq_window_q, acq_window_d;
   logic                 busy_q, busy_d;
   logic                 overrun_q, overrun_d;
   logic                 align_err_q, align_err_d;
   logic [AW-1:0]        align_cnt_q, align_cnt_d;
   logic                 cnt_load, cnt_dec, cnt_zero, align_to;
   logic [CNT_WIDTH-1:0] cnt_val;

   dcdc_down_counter #(.W(CNT_WIDTH)) u_cnt (
      .clk      (clk),
      .resetn   (resetn),
      .load     (cnt_load),
      .dec      (cnt_dec),
      .load_val (cnt_val),
      .zero     (cnt_zero)
   );

   always_comb begin
      state_d     = state_q;
      en_d        = en_q;
      state_out_d = state_out_q;
      align_cnt_d = '0;
      align_to    = 1'b0;
      cnt_load    = 1'b0;
      cnt_dec     = 1'b0;
      cnt_val     = '0;
      case (state_q)
         ST_IDLE: begin
            en_d        = sync_enable;
            state_out_d = park_level;
            if (acq_start) begin
               if (sync_enable) begin
                  state_d = ST_ALIGN;
               end else begin
                  state_d  = ST_GUARD;
                  cnt_load = 1'b1;
                  cnt_val  = pre_guard;
               end
            end
         end
         ST_ALIGN: begin
            align_cnt_d = align_cnt_q + AW'(1);
            // Compare against the latched level so a park_level change mid-align cannot cause a runt
            if (dcdc_clk_fb == state_out_q || align_cnt_q == ALIGN_LAST) begin
               align_to = (dcdc_clk_fb != state_out_q);
               state_d  = ST_GUARD;
               en_d     = DCDC_EN_PARK;
               cnt_load = 1'b1;
               cnt_val  = pre_guard;
            end
         end
         ST_GUARD: begin
            if (cnt_zero) begin
               state_d  = ST_ACQ;
               cnt_load = 1'b1;
               cnt_val  = (acq_len == '0) ? '0 : acq_len - CNT_WIDTH'(1);
            end else begin
               cnt_dec = 1'b1;
            end
         end
         default: begin
            if (cnt_zero) begin
               state_d = ST_IDLE;
               en_d    = sync_enable;
            end else begin
               cnt_dec = 1'b1;
            end
         end
      endcase
   end

   // Sticky flags: a set event in the same cycle as flags_clr wins
   always_comb begin
      busy_d       = (state_d != ST_IDLE);
      acq_window_d = (state_d == ST_ACQ);
      overrun_d    = (acq_start && busy_q) || (overrun_q && !flags_clr);
      align_err_d  = align_to || (align_err_q && !flags_clr);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= ST_IDLE;
         en_q         <= 1'b0;
         state_out_q  <= 1'b0;
         acq_window_q <= 1'b0;
         busy_q       <= 1'b0;
         overrun_q    <= 1'b0;
         align_err_q  <= 1'b0;
         align_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         en_q         <= en_d;
         state_out_q  <= state_out_d;
         acq_window_q <= acq_window_d;
         busy_q       <= busy_d;
         overrun_q    <= overrun_d;
         align_err_q  <= align_err_d;
         align_cnt_q  <= align_cnt_d;
      end
   end

   assign en         = en_q;
   assign state_out  = state_out_q;
   assign acq_window = acq_window_q;
   assign busy       = busy_q;
   assign overrun    = overrun_q;
   assign align_err  = align_err_q;

endmodule

// File: tb/tb_dcdc_quiet_ctrl.sv
// Bench for dcdc_quiet_ctrl: directed vector table, timeout/parked/reset
// sequences, and a randomized run against a schedule-based reference model.
module tb_dcdc_quiet_ctrl;

   localparam int N = 3000;
   localparam int M = N + 300;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        sync_enable = 1'b0, park_level = 1'b0, acq_start = 1'b0;
   logic        dcdc_clk_fb = 1'b0, flags_clr = 1'b0;
   logic [15:0] pre_guard = '0, acq_len = '0;
   logic        en, state_out, acq_window, busy, overrun, align_err;

   int vecs = 0;
   int errs = 0;

   dcdc_quiet_ctrl #(.CNT_WIDTH(16), .ALIGN_TIMEOUT(64)) dut (
      .clk(clk), .resetn(resetn), .sync_enable(sync_enable), .park_level(park_level),
      .acq_start(acq_start), .pre_guard(pre_guard), .acq_len(acq_len),
      .dcdc_clk_fb(dcdc_clk_fb), .flags_clr(flags_clr), .en(en), .state_out(state_out),
      .acq_window(acq_window), .busy(busy), .overrun(overrun), .align_err(align_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit st, se, pl, fb, clr;
      int pg, al;
      bit en, so, win, busy, ov, ae;
   } vec_t;

   vec_t tbl[11];

   // stimulus and expected-output arrays for the random run
   bit st_a[M], se_a[M], pl_a[M], fb_a[M], clr_a[M];
   int pg_a[M], al_a[M];
   bit e_busy[M], e_win[M], e_en[M], e_so[M], e_ov[M], e_ae[M], ae_set[M];
   int E, f, k, s, ee, run_fb, run_se, run_pl, cnt;
   bit to, v_fb, v_se, v_pl;

   task automatic chk(input string nm, input int act, input int exp_v);
      vecs++;
      if (act != exp_v) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
      end
   endtask

   task automatic chk_outs(input string tag, input bit xen, input bit xso, input bit xwin,
                           input bit xbusy, input bit xov, input bit xae);
      chk({tag, ".en"},         int'(en),         int'(xen));
      chk({tag, ".state_out"},  int'(state_out),  int'(xso));
      chk({tag, ".acq_window"}, int'(acq_window), int'(xwin));
      chk({tag, ".busy"},       int'(busy),       int'(xbusy));
      chk({tag, ".overrun"},    int'(overrun),    int'(xov));
      chk({tag, ".align_err"},  int'(align_err),  int'(xae));
   endtask

   task automatic hold_reset();
      @(negedge clk);
      resetn = 1'b0;
      acq_start = 1'b0; flags_clr = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      // ---------------- directed table: zero lengths, overrun, clear ----------------
      //          st se pl fb clr pg al | en so win busy ov ae
      tbl[0]  = '{0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0};
      tbl[1]  = '{1, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0};
      tbl[2]  = '{0, 1, 0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0};
      tbl[3]  = '{0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0};
      tbl[4]  = '{0, 1, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0};
      tbl[5]  = '{1, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0};
      tbl[6]  = '{1, 1, 0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0};
      tbl[7]  = '{0, 1, 0, 0, 1, 0, 0,   0, 0, 0, 1, 1, 0};
      tbl[8]  = '{1, 1, 0, 0, 1, 0, 0,   0, 0, 1, 1, 0, 0};
      tbl[9]  = '{0, 1, 0, 0, 1, 0, 0,   1, 0, 0, 0, 1, 0};
      tbl[10] = '{0, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0};

      hold_reset();
      chk_outs("reset", 0, 0, 0, 0, 0, 0);
      for (int r = 0; r < 11; r++) begin
         @(negedge clk);
         if (r == 0) resetn = 1'b1;
         chk_outs($sformatf("tbl[%0d]", r), tbl[r].en, tbl[r].so, tbl[r].win,
                  tbl[r].busy, tbl[r].ov, tbl[r].ae);
         acq_start   = tbl[r].st;  sync_enable = tbl[r].se; park_level = tbl[r].pl;
         dcdc_clk_fb = tbl[r].fb;  flags_clr   = tbl[r].clr;
         pre_guard   = 16'(tbl[r].pg); acq_len = 16'(tbl[r].al);
      end

      // ---------------- alignment timeout: fb stuck opposite to park level ----------------
      hold_reset();
      sync_enable = 1'b1; park_level = 1'b0; dcdc_clk_fb = 1'b1; pre_guard = 16'd2; acq_len = 16'd3;
      @(negedge clk); resetn = 1'b1;
      @(negedge clk); acq_start = 1'b1;
      @(negedge clk); acq_start = 1'b0;
      chk("timeout.busy_at_entry", int'(busy), 1);
      cnt = 0;
      while (en && cnt < 200) begin @(negedge clk); cnt++; end
      chk("timeout.en_fall_latency", cnt, 64);
      chk("timeout.align_err", int'(align_err), 1);
      cnt = 0;
      while (!acq_window && cnt < 50) begin @(negedge clk); cnt++; end
      chk("timeout.window_delay", cnt, 3);
      cnt = 0;
      while (acq_window && cnt < 50) begin @(negedge clk); cnt++; end
      chk("timeout.window_len", cnt, 3);
      chk("timeout.en_restored", int'(en), 1);
      flags_clr = 1'b1;
      @(negedge clk); flags_clr = 1'b0;
      chk("timeout.align_err_clr", int'(align_err), 0);

      // ---------------- parked mode and asynchronous mid-window reset ----------------
      hold_reset();
      sync_enable = 1'b0; park_level = 1'b1; dcdc_clk_fb = 1'b0; pre_guard = 16'd0; acq_len = 16'd5;
      @(negedge clk); resetn = 1'b1;
      @(negedge clk);
      chk("parked.en", int'(en), 0);
      chk("parked.state_out", int'(state_out), 1);
      acq_start = 1'b1;
      @(negedge clk); acq_start = 1'b0;
      chk("parked.busy", int'(busy), 1);
      chk("parked.en_low", int'(en), 0);
      @(negedge clk);
      chk("parked.window_skip_align", int'(acq_window), 1);
      @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      chk("midreset.acq_window", int'(acq_window), 0);
      chk("midreset.busy", int'(busy), 0);
      chk("midreset.state_out", int'(state_out), 0);

      // ---------------- randomized run against reference model ----------------
      run_fb = 0; run_se = 0; run_pl = 0;
      for (int i = 0; i < M; i++) begin
         if (run_fb == 0) begin v_fb = 1'($urandom_range(0, 1)); run_fb = $urandom_range(1, 90); end
         if (run_se == 0) begin v_se = ($urandom_range(0, 3) != 0); run_se = $urandom_range(1, 400); end
         if (run_pl == 0) begin v_pl = 1'($urandom_range(0, 1)); run_pl = $urandom_range(1, 200); end
         run_fb--; run_se--; run_pl--;
         fb_a[i] = v_fb; se_a[i] = v_se; pl_a[i] = v_pl;
         st_a[i]  = ($urandom_range(0, 5) == 0);
         clr_a[i] = ($urandom_range(0, 15) == 0);
         pg_a[i]  = $urandom_range(0, 6);
         al_a[i]  = $urandom_range(0, 6);
      end

      // Model: each accepted request becomes a schedule of (align end, window start, window end)
      E = -1;
      for (int t = 0; t < N; t++) begin
         if (t > E && st_a[t]) begin
            if (se_a[t]) begin
               to = 1'b1; k = 63;
               for (int j = 0; j < 64; j++)
                  if (to && fb_a[t + 1 + j] == pl_a[t]) begin k = j; to = 1'b0; end
               f = t + 2 + k;
            end else begin
               to = 1'b0; f = t + 1;
            end
            s  = f + pg_a[f - 1] + 1;
            ee = s + ((al_a[s - 1] == 0) ? 1 : al_a[s - 1]) - 1;
            for (int v = t + 1; v <= ee; v++) e_busy[v] = 1'b1;
            for (int v = s; v <= ee; v++)     e_win[v]  = 1'b1;
            for (int v = t + 1; v < f; v++)   e_en[v]   = 1'b1;
            if (to) ae_set[f] = 1'b1;
            E = ee;
         end
      end
      for (int v = 1; v <= N; v++) begin
         if (!e_busy[v]) e_en[v] = se_a[v - 1];
         e_so[v] = e_busy[v - 1] ? e_so[v - 1] : pl_a[v - 1];
         e_ov[v] = (st_a[v - 1] && e_busy[v - 1]) || (e_ov[v - 1] && !clr_a[v - 1]);
         e_ae[v] = ae_set[v] || (e_ae[v - 1] && !clr_a[v - 1]);
      end

      for (int c = 0; c <= N; c++) begin
         @(negedge clk);
         if (c == 0) resetn = 1'b1;
         chk_outs($sformatf("rand[%0d]", c), e_en[c], e_so[c], e_win[c], e_busy[c], e_ov[c], e_ae[c]);
         if (c < N) begin
            acq_start = st_a[c]; sync_enable = se_a[c]; park_level = pl_a[c];
            dcdc_clk_fb = fb_a[c]; flags_clr = clr_a[c];
            pre_guard = 16'(pg_a[c]); acq_len = 16'(al_a[c]);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
